circle_draw_ctrl: RTL
=====================

# circle_draw_ctrl

Sequencer between the board top level and the `circle` drawing engine. On `start` it clears the 160x120 framebuffer to a fixed colour, launches `circle` with latched geometry, and forwards its pixel stream to `vga_adapter` with off-screen points clipped. It owns the single VGA plot bus and arbitrates it between the clear sweep and the circle engine.

## Interface
Parameters:
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- CLEAR_COLOUR, 3'b000, colour written during the clear sweep

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- start  in  1  request; level, held high until `done` is seen
- centre_x  in  8  circle centre x, sampled on accepted start
- centre_y  in  7  circle centre y, sampled on accepted start
- radius  in  8  circle radius, sampled on accepted start
- colour  in  3  circle colour, sampled on accepted start
- done  out  1  operation complete
- circ_start  out  1  start to `circle`
- circ_centre_x / circ_centre_y / circ_radius / circ_colour  out  8/7/8/3  latched geometry to `circle`
- circ_done  in  1  done from `circle`
- circ_x / circ_y / circ_colour_in / circ_plot  in  8/7/3/1  pixel stream from `circle`
- vga_x / vga_y / vga_colour / vga_plot  out  8/7/3/1  pixel bus to `vga_adapter`

## Operation
- States: IDLE, CLEAR, DRAW, DONE.
- IDLE: all outputs 0. `start`=1 -> latch centre_x, centre_y, radius, colour; zero sweep counters; go CLEAR.
- CLEAR: one pixel per cycle, x outer (0..SCREEN_W-1), y inner (0..SCREEN_H-1). vga_x=cx, vga_y=cy, vga_colour=CLEAR_COLOUR, vga_plot=1. After (SCREEN_W-1, SCREEN_H-1) is plotted -> DRAW.
- DRAW: circ_start=1, held. vga_x/y/colour follow circ_x/y/colour_in; vga_plot = circ_plot & (circ_x < SCREEN_W) & (circ_y < SCREEN_H). circ_done=1 -> DONE.
- DONE: circ_start=0, done=1, vga_plot=0. Stays while `start`=1; `start`=0 -> IDLE.
- Latched geometry drives circ_* outputs constantly from latch; input changes after acceptance ignored.
- `start` dropped during CLEAR or DRAW: ignored; sequence completes; DONE then exits after one cycle (done pulses once).
- Comparisons unsigned; circ_x 8-bit so 160..255 clipped; circ_y 7-bit so 120..127 clipped.

## Timing
- Reset (async assert, sync release): state IDLE, counters 0, latches 0; done, circ_start, vga_plot, vga_x, vga_y, vga_colour all 0 immediately on rst_n low.
- Start accepted in cycle N (IDLE): first clear pixel (0,0) on bus in cycle N+1.
- Clear length exactly SCREEN_W*SCREEN_H = 19200 plotting cycles, N+1..N+19200, no gaps.
- circ_start rises in cycle N+19201.
- circ_done high in cycle M (DRAW): done=1 and circ_start=0 from cycle M+1.
- Pixel passthrough in DRAW is combinational (zero latency); clip gating adds no delay.
- Reset mid-CLEAR/DRAW: immediate abort to IDLE, vga_plot=0 same instant; next start restarts from clear.
- vga_plot never asserted in IDLE or DONE; never more than one source driving the bus.

## Structure
- Package `draw_pkg`: state enum (IDLE, CLEAR, DRAW, DONE), SCREEN_W/SCREEN_H defaults, CLEAR_COLOUR default.
- Sub-module `fill_sweep`: x/y raster counter with `en`, `clr`, `last` outputs; reusable by the fillscreen task.
- Top level instantiates `circle_draw_ctrl`, `circle`, and `vga_adapter` (160x120).

## Test plan
- Reset then start with centre (80,60), r=10, colour 3'b010: 19200 plots of colour 0 in raster order, (0,0) first, (159,119) last; then circ_start=1 next cycle.
- Behavioural `circle` model emits circ_x=170, circ_y=50, circ_plot=1 -> vga_plot=0; circ_x=159, circ_y=119 -> vga_plot=1.
- circ_done pulses in DRAW -> done=1, circ_start=0 next cycle; hold start 100 cycles -> done stays 1; drop start -> IDLE, done=0.
- Change centre_x/radius mid-CLEAR -> circ_centre_x/circ_radius hold latched values.
- Assert rst_n=0 at pixel 5000 of clear -> vga_plot=0 and state IDLE without waiting for clock; new start restarts at (0,0).
- Drop start during DRAW -> sequence completes, done high exactly one cycle, returns IDLE.

Source files
------------

// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Shared types and defaults for the circle drawing sequencer and its helpers.
//   draw_state_e      : sequencer state encoding (idle, clear, draw, done)
//   SCREEN_W_DEF      : default visible width in pixels
//   SCREEN_H_DEF      : default visible height in pixels
//   CLEAR_COLOUR_DEF  : default colour written by the clear sweep
// -----------------------------------------------------------------------------
package draw_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StClear = 2'd1,
      StDraw  = 2'd2,
      StDone  = 2'd3
   } draw_state_e;

   localparam int unsigned SCREEN_W_DEF     = 160;
   localparam int unsigned SCREEN_H_DEF     = 120;
   localparam logic [2:0]  CLEAR_COLOUR_DEF = 3'b000;

endpackage

// File: rtl/fill_sweep.sv
// -----------------------------------------------------------------------------
// fill_sweep
// Raster counter covering a W x H screen, x outer and y inner. Advances one
// pixel per enabled cycle and wraps back to (0,0) after the last pixel.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : advance to the next pixel
//   i_clr      : synchronously return to (0,0); wins over i_en
//   o_x, o_y   : current pixel coordinate
//   o_last     : current pixel is (W-1, H-1)
// -----------------------------------------------------------------------------
module fill_sweep
   import draw_pkg::*;
#(
   parameter int unsigned W = SCREEN_W_DEF,
   parameter int unsigned H = SCREEN_H_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   input  logic       i_clr,
   output logic [7:0] o_x,
   output logic [6:0] o_y,
   output logic       o_last
);

   localparam logic [7:0] XMax = 8'(W - 1);
   localparam logic [6:0] YMax = 7'(H - 1);

   logic [7:0] r_x;
   logic [6:0] r_y;
   logic       w_x_end;
   logic       w_y_end;

   assign w_x_end = (r_x == XMax);
   assign w_y_end = (r_y == YMax);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_clr) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_en) begin
         if (w_y_end) begin
            r_y <= '0;
            r_x <= w_x_end ? '0 : r_x + 8'd1;
         end else begin
            r_y <= r_y + 7'd1;
         end
      end
   end

   assign o_x    = r_x;
   assign o_y    = r_y;
   assign o_last = w_x_end & w_y_end;

endmodule

// File: rtl/circle_draw_ctrl.sv
// -----------------------------------------------------------------------------
// circle_draw_ctrl
// Sequencer in front of the circle engine. On start it clears the screen to
// CLEAR_COLOUR, then runs the circle engine with latched geometry and forwards
// its pixel stream to the VGA bus, dropping points that fall off-screen.
//   clk, rst_n               : clock, asynchronous active-low reset
//   i_start                  : level request, held until o_done is seen
//   i_centre_x/_y, i_radius,
//   i_colour                 : geometry, sampled when start is accepted
//   o_done                   : operation complete
//   o_circ_start             : start to the circle engine (held during draw)
//   o_circ_centre_x/_y,
//   o_circ_radius,
//   o_circ_colour            : latched geometry to the circle engine
//   i_circ_done              : completion from the circle engine
//   i_circ_x/_y, i_circ_colour,
//   i_circ_plot              : pixel stream from the circle engine
//   o_vga_x/_y, o_vga_colour,
//   o_vga_plot               : single pixel bus to the VGA adapter
// -----------------------------------------------------------------------------
module circle_draw_ctrl
   import draw_pkg::*;
#(
   parameter int unsigned SCREEN_W     = SCREEN_W_DEF,
   parameter int unsigned SCREEN_H     = SCREEN_H_DEF,
   parameter logic [2:0]  CLEAR_COLOUR = CLEAR_COLOUR_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic [7:0] i_centre_x,
   input  logic [6:0] i_centre_y,
   input  logic [7:0] i_radius,
   input  logic [2:0] i_colour,
   output logic       o_done,
   output logic       o_circ_start,
   output logic [7:0] o_circ_centre_x,
   output logic [6:0] o_circ_centre_y,
   output logic [7:0] o_circ_radius,
   output logic [2:0] o_circ_colour,
   input  logic       i_circ_done,
   input  logic [7:0] i_circ_x,
   input  logic [6:0] i_circ_y,
   input  logic [2:0] i_circ_colour,
   input  logic       i_circ_plot,
   output logic [7:0] o_vga_x,
   output logic [6:0] o_vga_y,
   output logic [2:0] o_vga_colour,
   output logic       o_vga_plot
);

   draw_state_e r_state;
   logic [7:0]  r_cx;
   logic [6:0]  r_cy;
   logic [7:0]  r_radius;
   logic [2:0]  r_colour;
   logic        r_done;
   logic        r_circ_start;

   logic [7:0]  w_sweep_x;
   logic [6:0]  w_sweep_y;
   logic        w_sweep_last;
   logic        w_sweep_en;
   logic        w_sweep_clr;
   logic        w_on_screen;

   // Sweep is parked at (0,0) whenever idle so a new start always begins there.
   assign w_sweep_en  = (r_state == StClear);
   assign w_sweep_clr = (r_state == StIdle);

   fill_sweep #(
      .W (SCREEN_W),
      .H (SCREEN_H)
   ) u_fill_sweep (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_sweep_en),
      .i_clr  (w_sweep_clr),
      .o_x    (w_sweep_x),
      .o_y    (w_sweep_y),
      .o_last (w_sweep_last)
   );

   // Sequencer: state plus registered done / circ_start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_cx         <= '0;
         r_cy         <= '0;
         r_radius     <= '0;
         r_colour     <= '0;
         r_done       <= 1'b0;
         r_circ_start <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_cx     <= i_centre_x;
                  r_cy     <= i_centre_y;
                  r_radius <= i_radius;
                  r_colour <= i_colour;
                  r_state  <= StClear;
               end
            end
            StClear: begin
               if (w_sweep_last) begin
                  r_state      <= StDraw;
                  r_circ_start <= 1'b1;
               end
            end
            StDraw: begin
               if (i_circ_done) begin
                  r_state      <= StDone;
                  r_circ_start <= 1'b0;
                  r_done       <= 1'b1;
               end
            end
            StDone: begin
               // A start dropped earlier makes this a single-cycle pulse.
               if (!i_start) begin
                  r_state <= StIdle;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state      <= StIdle;
               r_done       <= 1'b0;
               r_circ_start <= 1'b0;
            end
         endcase
      end
   end

   // Widened compares so the clip stays correct for any screen parameter.
   assign w_on_screen = ({1'b0, i_circ_x} < 9'(SCREEN_W)) &&
                        ({1'b0, i_circ_y} < 8'(SCREEN_H));

   // Bus mux: only the clear sweep or the engine ever drives it, never both.
   always_comb begin
      o_vga_x      = '0;
      o_vga_y      = '0;
      o_vga_colour = '0;
      o_vga_plot   = 1'b0;
      unique case (r_state)
         StClear: begin
            o_vga_x      = w_sweep_x;
            o_vga_y      = w_sweep_y;
            o_vga_colour = CLEAR_COLOUR;
            o_vga_plot   = 1'b1;
         end
         StDraw: begin
            o_vga_x      = i_circ_x;
            o_vga_y      = i_circ_y;
            o_vga_colour = i_circ_colour;
            o_vga_plot   = i_circ_plot & w_on_screen;
         end
         default: begin
            o_vga_plot = 1'b0;
         end
      endcase
   end

   assign o_done          = r_done;
   assign o_circ_start    = r_circ_start;
   assign o_circ_centre_x = r_cx;
   assign o_circ_centre_y = r_cy;
   assign o_circ_radius   = r_radius;
   assign o_circ_colour   = r_colour;

endmodule
